// File: rtl/ap_prof_pkg.sv
// Shared types for the ap_ctrl_hs transaction profiler: FSM states, timestamp-queue entries and output records.
package ap_prof_pkg;

  localparam int AP_CNT_W = 32;
  localparam int AP_ID_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PEND  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [AP_ID_W-1:0]  id;
    logic [AP_CNT_W-1:0] ts;
    logic [AP_CNT_W-1:0] interval;
  } ts_entry_t;

  typedef struct packed {
    logic [AP_ID_W-1:0]  id;
    logic [AP_CNT_W-1:0] start;
    logic [AP_CNT_W-1:0] latency;
    logic [AP_CNT_W-1:0] interval;
  } rec_t;

  // Timestamps wrap, so every difference is a plain truncated subtract.
  function automatic logic [AP_CNT_W-1:0] cyc_diff(input logic [AP_CNT_W-1:0] a,
                                                   input logic [AP_CNT_W-1:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/prof_sync_fifo.sv
// Generic synchronous FIFO, registered pointers; data at the head is visible the cycle after the push.
// A push while full is accepted only when a pop happens in the same cycle.
module prof_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ap_ctrl_txn_profiler.sv
// Taps ap_ctrl_hs and emits one {id,start,latency,interval} record per completion, 1 cycle after done.
// Records queue in an output FIFO under rec_valid/rec_ready; a full queue drops the record and flags overflow.
module ap_ctrl_txn_profiler
  import ap_prof_pkg::*;
#(
  parameter int CNT_W     = AP_CNT_W,
  parameter int ID_W      = AP_ID_W,
  parameter int TS_DEPTH  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [ID_W-1:0]  rec_id,
  output logic [CNT_W-1:0] rec_start,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [ID_W-1:0]  txn_count,
  output logic             overflow,
  output logic             drained
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cyc, pend_ts, prev_start, issue_ts, cur_interval;
  logic [ID_W-1:0]  next_id;
  logic             first;
  logic             issue_fire, pend_load, start_drop;

  logic             cpl, bypass, cpl_err;
  logic             ts_push, ts_pop, ts_full, ts_empty, ts_drop;
  logic             out_push, out_pop, out_full, out_empty, out_drop, rec_fire;
  ts_entry_t        ts_in, ts_head;
  rec_t             rec_in, out_head;

  always_comb begin
    state_n    = state;
    issue_fire = 1'b0;
    issue_ts   = cyc;
    pend_load  = 1'b0;
    start_drop = 1'b0;
    case (state)
      S_IDLE: begin
        if (ap_start) begin
          pend_load = 1'b1;
          if (ap_ready) issue_fire = 1'b1;
          else          state_n    = S_PEND;
        end else if (finish) begin
          state_n = S_DRAIN;
        end
      end
      S_PEND: begin
        issue_ts = pend_ts;
        if (ap_ready) begin
          issue_fire = 1'b1;
          state_n    = S_IDLE;
        end else if (!ap_start) begin
          start_drop = 1'b1;
          state_n    = S_IDLE;
        end
      end
      S_DRAIN: state_n = S_DRAIN;
      default: state_n = S_IDLE;
    endcase
  end

  assign cur_interval = first ? '0 : cyc_diff(issue_ts, prev_start);
  assign ts_in        = '{id: next_id, ts: issue_ts, interval: cur_interval};

  // A completion racing its own issue against an empty queue never touches the ts FIFO.
  assign cpl      = ap_done & ap_continue;
  assign bypass   = cpl & issue_fire & ts_empty;
  assign cpl_err  = cpl & ts_empty & ~issue_fire;
  assign ts_pop   = cpl & ~ts_empty;
  assign ts_push  = issue_fire & ~bypass;
  assign ts_drop  = ts_push & ts_full & ~ts_pop;
  assign rec_fire = bypass | ts_pop;

  always_comb begin
    rec_in = '0;
    if (bypass) begin
      rec_in = '{id: next_id, start: issue_ts, latency: cyc_diff(cyc, issue_ts),
                 interval: cur_interval};
    end else begin
      rec_in = '{id: ts_head.id, start: ts_head.ts, latency: cyc_diff(cyc, ts_head.ts),
                 interval: ts_head.interval};
    end
  end

  assign out_pop  = rec_valid & rec_ready;
  assign out_push = rec_fire;
  assign out_drop = rec_fire & out_full & ~out_pop;

  prof_sync_fifo #(.T(ts_entry_t), .DEPTH(TS_DEPTH)) u_ts_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (ts_push),
    .push_data (ts_in),
    .pop       (ts_pop),
    .pop_data  (ts_head),
    .full      (ts_full),
    .empty     (ts_empty)
  );

  prof_sync_fifo #(.T(rec_t), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (out_push),
    .push_data (rec_in),
    .pop       (out_pop),
    .pop_data  (out_head),
    .full      (out_full),
    .empty     (out_empty)
  );

  // Head data is masked while empty so the stale FIFO slot never leaks out.
  assign rec_valid    = ~out_empty;
  assign rec_id       = rec_valid ? out_head.id       : '0;
  assign rec_start    = rec_valid ? out_head.start    : '0;
  assign rec_latency  = rec_valid ? out_head.latency  : '0;
  assign rec_interval = rec_valid ? out_head.interval : '0;
  assign drained      = (state == S_DRAIN) & ts_empty & out_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cyc        <= '0;
      pend_ts    <= '0;
      prev_start <= '0;
      first      <= 1'b1;
      next_id    <= '0;
      txn_count  <= '0;
      overflow   <= 1'b0;
    end else begin
      state <= state_n;
      cyc   <= cyc + 1'b1;
      if (pend_load) pend_ts <= cyc;
      if (issue_fire) begin
        prev_start <= issue_ts;
        first      <= 1'b0;
        next_id    <= next_id + 1'b1;
      end
      if (rec_fire) txn_count <= txn_count + 1'b1;
      if (start_drop | ts_drop | out_drop | cpl_err) overflow <= 1'b1;
    end
  end

endmodule
